// File: rtl/adc_readout.sv
`default_nettype none
// ============================================================================
//  Module      : adc_readout
//  Description : Serial readout engine for a SAR ADC. Each trigger pulse
//                clocks DATA_WIDTH bits out of the ADC over sck/sdo (MSB
//                first). The sample is presented on an AXI-Stream master
//                with sign extension. A frame counter drives tlast and a
//                one-cycle 'last' pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_readout #(
   parameter int DATA_WIDTH = 24,   // ADC sample width, 1..32
   parameter int SCK_DIV    = 2     // sck half-period in clk cycles, >= 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        trigger,
   input  logic [31:0] num_samples,
   input  logic        clear,
   output logic        sck,
   input  logic        sdo,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        last,
   output logic        overrun,
   output logic        active
);

   localparam int c_div_w = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int c_bit_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCK_DIV - 1);
   localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic                   r_sck;
   logic [c_div_w-1:0]     r_div_cnt;
   logic [c_bit_w-1:0]     r_bit_cnt;
   logic [DATA_WIDTH-1:0]  r_shift;

   logic [31:0]            r_tdata;
   logic                   r_tvalid;
   logic                   r_tlast;
   logic [31:0]            r_count;
   logic                   r_overrun;

   logic                   w_shifting;
   logic                   w_div_last;
   logic                   w_fall;
   logic                   w_period_end;
   logic                   w_done;
   logic                   w_accept;
   logic                   w_drop;
   logic                   w_trig_ovr;
   logic                   w_frame_end;
   logic [31:0]            w_sext;

   assign w_shifting   = (r_state == S_SHIFT);
   assign w_div_last   = (r_div_cnt == c_div_last);
   // sck falls at the end of the high phase: sample sdo there
   assign w_fall       = w_shifting &&  r_sck && w_div_last;
   // end of the low phase closes one full sck period
   assign w_period_end = w_shifting && !r_sck && w_div_last;
   // the readout is complete once the last period's low phase has elapsed,
   // which keeps SHIFT exactly 2*SCK_DIV*DATA_WIDTH cycles long
   assign w_done       = w_period_end && (r_bit_cnt == c_bit_last);
   assign w_accept     = r_tvalid && m_axis_tready;
   assign w_drop       = w_done && r_tvalid && !m_axis_tready;
   assign w_trig_ovr   = w_shifting && trigger;
   assign w_frame_end  = (num_samples != 32'd0) && (r_count == (num_samples - 32'd1));

   // sign-extend the captured word to the 32-bit stream width
   generate
      if (DATA_WIDTH < 32) begin : g_sext
         assign w_sext = {{(32 - DATA_WIDTH){r_shift[DATA_WIDTH-1]}}, r_shift};
      end else begin : g_full
         assign w_sext = r_shift;
      end
   endgenerate

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic: triggers in SHIFT are ignored here and flagged as overrun
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (trigger) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_done)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // sck generation, period counting and MSB-first shift register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sck     <= 1'b0;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (trigger) begin
                  r_sck     <= 1'b1;
                  r_div_cnt <= '0;
                  r_bit_cnt <= '0;
               end
            end
            S_SHIFT: begin
               if (w_div_last) begin
                  r_div_cnt <= '0;
                  if (r_sck) begin
                     r_sck <= 1'b0;
                  end else if (!w_done) begin
                     r_sck     <= 1'b1;
                     r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + c_div_w'(1);
               end
               if (w_fall) begin
                  r_shift <= (r_shift << 1) | DATA_WIDTH'(sdo);
               end
            end
            default: r_sck <= 1'b0;
         endcase
      end
   end

   // single-entry output register with frame counter; a busy register drops the new word
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_done && !w_drop) begin
            r_tdata  <= w_sext;
            r_tvalid <= 1'b1;
            r_tlast  <= w_frame_end;
            r_count  <= w_frame_end ? 32'd0 : (r_count + 32'd1);
         end else if (w_accept) begin
            r_tvalid <= 1'b0;
         end
         if (clear) begin
            r_count <= '0;
         end
      end
   end

   // sticky overrun flag; clear has priority over a coincident set
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_overrun <= 1'b0;
      end else if (clear) begin
         r_overrun <= 1'b0;
      end else if (w_trig_ovr || w_drop) begin
         r_overrun <= 1'b1;
      end
   end

   assign sck           = r_sck;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign last          = r_tvalid && m_axis_tready && r_tlast;
   assign overrun       = r_overrun;
   assign active        = w_shifting;

endmodule
`default_nettype wire

// File: tb/tb_adc_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_readout
//  Description : Self-checking bench for adc_readout (DATA_WIDTH=24,
//                SCK_DIV=2). Vector table plus directed corner sequences,
//                with a scoreboard queue checked on stream acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_readout;

   localparam int DW  = 24;
   localparam int DIV = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        trigger = 1'b0;
   logic [31:0] num_samples = 32'd0;
   logic        clear = 1'b0;
   logic        sck;
   logic        sdo = 1'b0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        last;
   logic        overrun;
   logic        active;

   adc_readout #(.DATA_WIDTH(DW), .SCK_DIV(DIV)) u_dut (
      .clk           (clk),
      .resetn        (resetn),
      .trigger       (trigger),
      .num_samples   (num_samples),
      .clear         (clear),
      .sck           (sck),
      .sdo           (sdo),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .last          (last),
      .overrun       (overrun),
      .active        (active)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // scoreboard
   typedef struct {
      logic [31:0] d;
      logic        l;
   } exp_t;
   exp_t sb[$];

   // ADC model: presents the next bit on each sck rise, measures sck period
   logic [23:0] adc_word = 24'd0;
   int          pulses = 0;
   int          cyc = 0;
   int          last_rise = -1;
   int          period = 0;
   logic        prev_sck = 1'b0;
   int          n_last_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (sck && !prev_sck) begin
         if (pulses < DW) sdo = adc_word[DW-1-pulses];
         if (last_rise >= 0) period = cyc - last_rise;
         last_rise = cyc;
         pulses++;
      end
      prev_sck = sck;
      if (last) n_last_cyc++;
   end

   // stream monitor: compare each accepted word against the scoreboard
   always @(negedge clk) begin
      if (resetn && m_axis_tvalid && m_axis_tready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected none", m_axis_tdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("tdata", m_axis_tdata, e.d);
            chk("tlast", {31'd0, m_axis_tlast}, {31'd0, e.l});
            chk("last_pulse", {31'd0, last}, {31'd0, e.l});
         end
      end
   end

   // one complete readout; optional retrigger while shifting
   task automatic run_one(input logic [23:0] w, input bit push, input logic [31:0] ed,
                          input logic el, input bit chk_lat, input int retrig_at);
      int lat;
      adc_word  = w;
      pulses    = 0;
      last_rise = -1;
      chk("sck_idle_before", {31'd0, sck}, 32'd0);
      if (push) sb.push_back('{ed, el});
      @(posedge clk); #1 trigger = 1'b1;
      @(posedge clk); #1 trigger = 1'b0;
      chk("sck_high_after_trig", {31'd0, sck}, 32'd1);
      chk("active_in_shift", {31'd0, active}, 32'd1);
      lat = -1;
      for (int i = 1; i <= 110; i++) begin
         @(posedge clk); #1;
         if (i == retrig_at)     trigger = 1'b1;
         if (i == retrig_at + 1) trigger = 1'b0;
         if (lat < 0 && m_axis_tvalid) lat = i + 1;
      end
      if (chk_lat) chk("latency", lat, 32'd97);
      chk("sck_pulses", pulses, DW);
      chk("sck_period", period, 2 * DIV);
      chk("sck_idle_after", {31'd0, sck}, 32'd0);
      chk("active_done", {31'd0, active}, 32'd0);
      if (m_axis_tready) chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic pulse_clear(input logic [31:0] ns);
      @(posedge clk); #1 clear = 1'b1; num_samples = ns;
      @(posedge clk); #1 clear = 1'b0;
   endtask

   typedef struct {
      logic        do_clr;
      logic [31:0] ns;
      logic [23:0] word;
      logic [31:0] exp_d;
      logic        exp_l;
   } vec_t;
   vec_t vecs[11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{1'b1, 32'd0, 24'hA5A5A5, 32'hFFA5A5A5, 1'b0};
      vecs[1]  = '{1'b0, 32'd0, 24'h123456, 32'h00123456, 1'b0};
      vecs[2]  = '{1'b0, 32'd0, 24'h800000, 32'hFF800000, 1'b0};
      vecs[3]  = '{1'b0, 32'd0, 24'h7FFFFF, 32'h007FFFFF, 1'b0};
      vecs[4]  = '{1'b1, 32'd3, 24'h000001, 32'h00000001, 1'b0};
      vecs[5]  = '{1'b0, 32'd3, 24'h000002, 32'h00000002, 1'b0};
      vecs[6]  = '{1'b0, 32'd3, 24'hFFFFFF, 32'hFFFFFFFF, 1'b1};
      vecs[7]  = '{1'b0, 32'd3, 24'h000000, 32'h00000000, 1'b0};
      vecs[8]  = '{1'b0, 32'd3, 24'h5A5A5A, 32'h005A5A5A, 1'b0};
      vecs[9]  = '{1'b0, 32'd3, 24'h00000F, 32'h0000000F, 1'b1};
      vecs[10] = '{1'b0, 32'd1, 24'h0AAAAA, 32'h000AAAAA, 1'b1};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sck",     {31'd0, sck},           32'd0);
      chk("rst_tvalid",  {31'd0, m_axis_tvalid}, 32'd0);
      chk("rst_tlast",   {31'd0, m_axis_tlast},  32'd0);
      chk("rst_tdata",   m_axis_tdata,           32'd0);
      chk("rst_overrun", {31'd0, overrun},       32'd0);
      chk("rst_active",  {31'd0, active},        32'd0);
      resetn = 1'b1;
      repeat (2) @(posedge clk);

      // table-driven readouts with tready held high
      for (int v = 0; v < 11; v++) begin
         if (vecs[v].do_clr) pulse_clear(vecs[v].ns);
         else num_samples = vecs[v].ns;
         run_one(vecs[v].word, 1'b1, vecs[v].exp_d, vecs[v].exp_l, 1'b1, 0);
      end
      chk("last_pulse_cycles", n_last_cyc, 32'd3);

      // backpressure: first word held, second dropped, overrun set then cleared
      pulse_clear(32'd0);
      m_axis_tready = 1'b0;
      run_one(24'h111111, 1'b1, 32'h00111111, 1'b0, 1'b1, 0);
      chk("hold_tvalid",  {31'd0, m_axis_tvalid}, 32'd1);
      chk("hold_tdata",   m_axis_tdata,           32'h00111111);
      chk("no_ovr_yet",   {31'd0, overrun},       32'd0);
      run_one(24'h222222, 1'b0, 32'd0, 1'b0, 1'b0, 0);
      chk("held_tdata",   m_axis_tdata,           32'h00111111);
      chk("held_tvalid",  {31'd0, m_axis_tvalid}, 32'd1);
      chk("held_tlast",   {31'd0, m_axis_tlast},  32'd0);
      chk("drop_overrun", {31'd0, overrun},       32'd1);
      @(posedge clk); #1 m_axis_tready = 1'b1;
      @(posedge clk); #1;
      chk("tvalid_drop_after_acc", {31'd0, m_axis_tvalid}, 32'd0);
      chk("sb_after_acc", 32'(sb.size()), 32'd0);
      pulse_clear(32'd0);
      chk("clear_overrun", {31'd0, overrun}, 32'd0);

      // retrigger during SHIFT: ignored, one word, overrun set
      run_one(24'h3C3C3C, 1'b1, 32'h003C3C3C, 1'b0, 1'b1, 10);
      chk("retrig_overrun", {31'd0, overrun}, 32'd1);
      pulse_clear(32'd0);

      // reset in the middle of a readout
      adc_word  = 24'hFFFFFF;
      pulses    = 0;
      last_rise = -1;
      @(posedge clk); #1 trigger = 1'b1;
      @(posedge clk); #1 trigger = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (pulses >= 12) break;
         @(posedge clk); #1;
      end
      chk("reached_pulse12", {31'd0, pulses >= 12}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("midrst_sck",    {31'd0, sck},           32'd0);
      chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("midrst_active", {31'd0, active},        32'd0);
      #2 resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_no_word", {31'd0, m_axis_tvalid}, 32'd0);
      run_one(24'h654321, 1'b1, 32'h00654321, 1'b0, 1'b1, 0);

      repeat (5) @(posedge clk);
      chk("sb_final", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
